ps2_host_tx: RTL

PS/2 host-to-device transmitter. It sends one command byte, such as 0xED (set LEDs), 0xF4 (enable reporting) or 0xFF (reset), from the SoC to a PS/2 keyboard or mouse over the open-drain clock/data pair. It is the transmit counterpart of the PS/2 keyboard receiver and sits beside it in the top level, driving the same pins through `1'bz`/`1'b0` tristate assignments. The block performs the full request-to-send sequence: inhibit, start bit, 8 data bits, odd parity, stop, and device ACK check, with a timeout.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame bit positions
// and the odd-parity helper used by both the host transmitter and receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        WAITREL
    } tx_state_e;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] bit_cnt_t;

    // Device falling-edge count values while in DATA (bit0 is driven from REQ).
    localparam bit_cnt_t CNT_FIRST_DATA = 4'd1;
    localparam bit_cnt_t CNT_PARITY     = 4'd8;
    localparam bit_cnt_t CNT_STOP       = 4'd9;
    localparam bit_cnt_t CNT_ACK        = 4'd10;

    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus falling-edge detect.
// Flops reset high because a released open-drain line idles high.
module ps2_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd
// parity, stop and ACK check. Outputs are 1 = release, 0 = drive low.
module ps2_host_tx #(
    parameter int FREQ_HZ    = 12000000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       timeout_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o
);

    import ps2_pkg::*;

    localparam int INHIBIT_CYCLES = FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYCLES = FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TIMER_W        = $clog2(TIMEOUT_CYCLES + 1);

    typedef logic [TIMER_W-1:0] timer_t;

    // Timer holds the number of non-IDLE cycles already elapsed, so the
    // thresholds are compared one below the cycle counts.
    localparam timer_t INHIBIT_LAST = timer_t'(INHIBIT_CYCLES - 1);
    localparam timer_t TIMEOUT_LAST = timer_t'(TIMEOUT_CYCLES - 1);

    tx_state_e state_q, state_d;
    timer_t    timer_q, timer_d;
    bit_cnt_t  count_q, count_d;
    logic [7:0] byte_q, byte_d;
    logic      parity_q, parity_d;
    logic      ack_bit_q, ack_bit_d;

    logic      clk_q, clk_d;
    logic      data_q, data_d;
    logic      done_q, done_d;
    logic      ack_err_q, ack_err_d;
    logic      timeout_q, timeout_d;

    logic      clk_level;
    logic      clk_fall;
    logic      data_level;
    logic      data_fall_unused;

    logic      accept;
    logic      timeout_hit;
    logic      released;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .reset (reset),
        .line  (ps2_data_i),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    assign accept      = valid_i && (state_q == IDLE);
    assign timeout_hit = (state_q != IDLE) && (timer_q == TIMEOUT_LAST);
    assign released    = clk_level && data_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            clk_q     <= 1'b1;
            data_q    <= 1'b1;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            clk_q     <= clk_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    // NOTE: payload registers are loaded before every use, so they carry no reset.
    always_ff @(posedge clk) begin
        byte_q    <= byte_d;
        parity_q  <= parity_d;
        ack_bit_q <= ack_bit_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        ack_bit_d = ack_bit_q;
        timer_d   = (state_q == IDLE) ? '0 : timer_q + timer_t'(1);

        if (timeout_hit) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d  = INHIBIT;
                        byte_d   = data_i;
                        parity_d = odd_parity(data_i);
                        count_d  = '0;
                    end
                end
                INHIBIT: begin
                    if (timer_q == INHIBIT_LAST) state_d = REQ;
                end
                REQ: begin
                    if (clk_fall) begin
                        state_d = DATA;
                        count_d = CNT_FIRST_DATA;
                    end
                end
                DATA: begin
                    if (clk_fall) begin
                        count_d = count_q + bit_cnt_t'(1);
                        if (count_q == CNT_ACK) begin
                            ack_bit_d = data_level;
                            state_d   = WAITREL;
                        end
                    end
                end
                WAITREL: begin
                    if (released) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered pin drivers and status pulses.
    always_comb begin
        clk_d     = 1'b1;
        data_d    = data_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b0;

        if (timeout_hit) begin
            data_d    = 1'b1;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: data_d = 1'b1;
                INHIBIT: begin
                    clk_d  = 1'b0;
                    data_d = 1'b1;
                end
                REQ: data_d = clk_fall ? byte_q[0] : 1'b0;
                DATA: begin
                    if (clk_fall) begin
                        case (count_q)
                            4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd7: data_d = byte_q[count_q[2:0]];
                            CNT_PARITY:       data_d = parity_q;
                            default:          data_d = 1'b1;
                        endcase
                    end
                end
                WAITREL: begin
                    data_d = 1'b1;
                    if (released) begin
                        done_d    = 1'b1;
                        ack_err_d = ack_bit_q;
                    end
                end
                default: data_d = 1'b1;
            endcase
        end
    end

    assign ready_o    = (state_q == IDLE) || reset;
    assign busy_o     = !ready_o;
    assign done_o     = done_q;
    assign ack_err_o  = ack_err_q;
    assign timeout_o  = timeout_q;
    assign ps2_clk_o  = clk_q;
    assign ps2_data_o = data_q;

endmodule
